// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: shares one FIFO write port among NUM_REQ
// valid/ready producers, granting bursts of up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_w_en,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic [ID_W-1:0]  last_owner, last_owner_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [ID_W-1:0]  rr_pick;
    logic             rr_found;
    logic             owner_valid;

    assign owner_valid = req_valid[owner];
    assign busy        = (state == GRANT);
    assign grant_id    = owner;

    // State and arbitration bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // First valid requester after last_owner, wrapping modulo NUM_REQ.
    always_comb begin
        rr_pick  = last_owner;
        rr_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req_valid[ID_W'((32'(last_owner) + k) % NUM_REQ)]) begin
                rr_pick  = ID_W'((32'(last_owner) + k) % NUM_REQ);
                rr_found = 1'b1;
            end
        end
    end

    // Next-state: grant on any request, release on owner idle or burst end.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_nxt     = GRANT;
                    owner_nxt     = rr_pick;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                end else if (!fifo_full) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: only the owner sees ready, and never while the FIFO is full.
    always_comb begin
        req_ready    = '0;
        fifo_w_en    = 1'b0;
        fifo_data_in = '0;
        if (state == GRANT) begin
            req_ready[owner] = !fifo_full;
            fifo_w_en        = owner_valid && !fifo_full;
            fifo_data_in     = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_data_in;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q[N][$];
    bit            hold_off[N];
    bit            gap_en;

    logic          o_busy, o_wen;
    logic [1:0]    o_gid;
    logic [N-1:0]  o_ready, o_valid;
    logic [DW-1:0] o_data;
    logic [DW-1:0] written[$];
    logic [1:0]    wr_id[$];

    // Producers present the head of their queue; gaps optionally randomized.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (q[i].size() != 0) && !hold_off[i] &&
                           (!gap_en || ($urandom_range(3) != 0));
            req_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    // One clock: sample at negedge, retire accepted beats at posedge, re-drive.
    task automatic tick();
        @(negedge clk);
        o_busy  = busy;
        o_wen   = fifo_w_en;
        o_gid   = grant_id;
        o_ready = req_ready;
        o_data  = fifo_data_in;
        o_valid = req_valid;
        if (fifo_w_en) begin
            written.push_back(fifo_data_in);
            wr_id.push_back(grant_id);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (o_ready[i] && o_valid[i] && q[i].size() != 0) void'(q[i].pop_front());
        #1;
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            hold_off[i] = 1'b0;
        end
        gap_en    = 1'b0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        written.delete();
        wr_id.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) q[i].push_back(8'hEE);
        rst_n = 1'b0;
        drive();
        tick();
        tick();
        n_vec += 5;
        if (o_busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        if (o_wen !== 1'b0)        begin n_err++; $display("FAIL reset_w_en: got %b expected 0", o_wen); end
        if (o_ready !== '0)        begin n_err++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
        if (o_gid !== 2'd0)        begin n_err++; $display("FAIL reset_gid: got %0d expected 0", o_gid); end
        if (o_data !== '0)         begin n_err++; $display("FAIL reset_data: got %h expected 00", o_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit [0:9]      e_wen  = 10'b0111101100;
        bit [0:9]      e_busy = 10'b0111101110;
        logic [DW-1:0] e_dat[10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00, 8'h00};
        do_reset();
        for (int b = 0; b < 6; b++) q[0].push_back(DW'(8'h10 + b));
        drive();
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec += 4;
            if (o_wen !== e_wen[c])   begin n_err++; $display("FAIL single_w_en c%0d: got %b expected %b", c, o_wen, e_wen[c]); end
            if (o_busy !== e_busy[c]) begin n_err++; $display("FAIL single_busy c%0d: got %b expected %b", c, o_busy, e_busy[c]); end
            if (o_data !== e_dat[c])  begin n_err++; $display("FAIL single_data c%0d: got %h expected %h", c, o_data, e_dat[c]); end
            if (o_gid !== 2'd0)       begin n_err++; $display("FAIL single_gid c%0d: got %0d expected 0", c, o_gid); end
        end
    endtask

    task automatic test_alternate();
        int            last_c = -1;
        int            g, r, beat;
        logic [DW-1:0] exp;
        do_reset();
        for (int b = 0; b < 12; b++) begin
            q[0].push_back(DW'(8'h20 + b));
            q[1].push_back(DW'(8'h40 + b));
        end
        drive();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_wen) last_c = c;
        end
        n_vec++;
        if (written.size() != 24) begin n_err++; $display("FAIL alt_count: got %0d expected 24", written.size()); end
        for (int k = 0; k < 24 && k < written.size(); k++) begin
            g    = k / 4;
            r    = g % 2;
            beat = (g / 2) * 4 + k % 4;
            exp  = DW'((r != 0 ? 8'h40 : 8'h20) + beat);
            n_vec += 2;
            if (written[k] !== exp)  begin n_err++; $display("FAIL alt_data k%0d: got %h expected %h", k, written[k], exp); end
            if (wr_id[k] !== 2'(r))  begin n_err++; $display("FAIL alt_id k%0d: got %0d expected %0d", k, wr_id[k], r); end
        end
        n_vec++;
        if (last_c != 29) begin n_err++; $display("FAIL alt_last_write_cycle: got %0d expected 29", last_c); end
    endtask

    task automatic test_all4();
        int   order[$];
        logic prevb = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < (i == 0 ? 8 : 4); b++) q[i].push_back(DW'(i * 16 + b));
        drive();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_busy && !prevb) order.push_back(int'(o_gid));
            prevb = o_busy;
        end
        n_vec += 2;
        if (order.size() != 5)    begin n_err++; $display("FAIL all4_grants: got %0d expected 5", order.size()); end
        if (written.size() != 20) begin n_err++; $display("FAIL all4_beats: got %0d expected 20", written.size()); end
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            n_vec++;
            if (order[k] != k % N) begin n_err++; $display("FAIL all4_order k%0d: got %0d expected %0d", k, order[k], k % N); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int b = 0; b < 4; b++) q[0].push_back(DW'(8'h50 + b));
        drive();
        tick();
        tick();
        tick();
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_vec += 4;
            if (o_wen !== 1'b0)            begin n_err++; $display("FAIL stall_w_en s%0d: got %b expected 0", s, o_wen); end
            if (o_ready !== '0)            begin n_err++; $display("FAIL stall_ready s%0d: got %b expected 0", s, o_ready); end
            if (o_busy !== 1'b1)           begin n_err++; $display("FAIL stall_busy s%0d: got %b expected 1", s, o_busy); end
            if (dut.burst_cnt !== 3'd2)    begin n_err++; $display("FAIL stall_cnt s%0d: got %0d expected 2", s, dut.burst_cnt); end
        end
        fifo_full = 1'b0;
        tick();
        tick();
        n_vec += 2;
        if (o_wen !== 1'b1 || o_data !== 8'h53) begin n_err++; $display("FAIL stall_beat4: got w_en=%b data=%h expected 1/53", o_wen, o_data); end
        tick();
        if (o_busy !== 1'b0) begin n_err++; $display("FAIL stall_release: got busy=%b expected 0", o_busy); end
        n_vec++;
        if (written.size() != 4) begin n_err++; $display("FAIL stall_count: got %0d expected 4", written.size()); end
        for (int k = 0; k < 4 && k < written.size(); k++) begin
            n_vec++;
            if (written[k] !== DW'(8'h50 + k)) begin n_err++; $display("FAIL stall_data k%0d: got %h expected %h", k, written[k], 8'h50 + k); end
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            q[0].push_back(DW'(8'h60 + b));
            q[2].push_back(DW'(8'h70 + b));
        end
        drive();
        tick();
        tick();
        n_vec++;
        if (o_wen !== 1'b1 || o_data !== 8'h60 || o_gid !== 2'd0) begin n_err++; $display("FAIL drop_beat1: got w_en=%b data=%h gid=%0d expected 1/60/0", o_wen, o_data, o_gid); end
        hold_off[0] = 1'b1;
        drive();
        tick();
        n_vec += 2;
        if (o_busy !== 1'b1 || o_wen !== 1'b0) begin n_err++; $display("FAIL drop_cycle: got busy=%b w_en=%b expected 1/0", o_busy, o_wen); end
        if (dut.last_owner !== 2'd0) begin n_err++; $display("FAIL drop_last_owner: got %0d expected 0", dut.last_owner); end
        tick();
        n_vec++;
        if (o_busy !== 1'b0) begin n_err++; $display("FAIL drop_bubble: got busy=%b expected 0", o_busy); end
        tick();
        n_vec++;
        if (o_busy !== 1'b1 || o_gid !== 2'd2 || o_data !== 8'h70) begin n_err++; $display("FAIL drop_regrant: got busy=%b gid=%0d data=%h expected 1/2/70", o_busy, o_gid, o_data); end
        hold_off[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        q[0].push_back(8'hA0);
        for (int b = 0; b < 4; b++) q[1].push_back(DW'(8'h90 + b));
        drive();
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (o_wen !== 1'b1 || o_data !== 8'h91 || o_gid !== 2'd1) begin n_err++; $display("FAIL rmid_beat2: got w_en=%b data=%h gid=%0d expected 1/91/1", o_wen, o_data, o_gid); end
        rst_n = 1'b1;
        q[0].push_back(8'hA1);
        drive();
        tick();
        n_vec += 4;
        if (o_busy !== 1'b0)  begin n_err++; $display("FAIL rmid_busy: got %b expected 0", o_busy); end
        if (o_wen !== 1'b0)   begin n_err++; $display("FAIL rmid_w_en: got %b expected 0", o_wen); end
        if (o_ready !== '0)   begin n_err++; $display("FAIL rmid_ready: got %b expected 0", o_ready); end
        if (o_gid !== 2'd0)   begin n_err++; $display("FAIL rmid_gid: got %0d expected 0", o_gid); end
        tick();
        n_vec++;
        if (o_busy !== 1'b1 || o_gid !== 2'd0 || o_data !== 8'hA1) begin n_err++; $display("FAIL rmid_first_winner: got busy=%b gid=%0d data=%h expected 1/0/A1", o_busy, o_gid, o_data); end
    endtask

    // Model: a grant serves one requester until it goes idle or has had MB
    // beats; the next grant goes to the nearest waiting requester after it.
    task automatic test_random();
        bit            m_busy = 1'b0;
        int            m_owner = 0;
        int            m_last = N - 1;
        int            m_beats = 0;
        bit            e_wen, found;
        logic [N-1:0]  e_ready, v;
        logic [DW-1:0] e_data;
        bit            f;
        int            cand;
        do_reset();
        gap_en = 1'b1;
        for (int i = 0; i < N; i++)
            for (int b = 0; b < int'($urandom_range(12)); b++) q[i].push_back(DW'($urandom));
        drive();
        for (int c = 0; c < 400; c++) begin
            v       = req_valid;
            f       = fifo_full;
            e_ready = '0;
            if (m_busy && !f) e_ready[m_owner] = 1'b1;
            e_wen   = m_busy && v[m_owner] && !f;
            e_data  = (m_busy && q[m_owner].size() != 0) ? q[m_owner][0] : '0;
            tick();
            n_vec += 5;
            if (o_busy !== m_busy)        begin n_err++; $display("FAIL rand_busy c%0d: got %b expected %b", c, o_busy, m_busy); end
            if (o_gid !== 2'(m_owner))    begin n_err++; $display("FAIL rand_gid c%0d: got %0d expected %0d", c, o_gid, m_owner); end
            if (o_ready !== e_ready)      begin n_err++; $display("FAIL rand_ready c%0d: got %b expected %b", c, o_ready, e_ready); end
            if (o_wen !== e_wen)          begin n_err++; $display("FAIL rand_w_en c%0d: got %b expected %b", c, o_wen, e_wen); end
            if (o_data !== e_data)        begin n_err++; $display("FAIL rand_data c%0d: got %h expected %h", c, o_data, e_data); end
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    cand = (m_last + k) % N;
                    if (!found && v[cand]) begin
                        found   = 1'b1;
                        m_owner = cand;
                    end
                end
                if (found) begin
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end else if (!v[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else if (!f) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
            fifo_full = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) q[$urandom_range(N - 1)].push_back(DW'($urandom));
            drive();
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_all4();
        test_stall();
        test_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `synchronous_fifo` write port among `NUM_REQ` producers. It takes per-requester valid/ready streams and grants the FIFO to one requester at a time, for a burst of up to `MAX_BURST` beats. It drives the FIFO's `w_en`/`data_in` and stalls on the FIFO's `full`. It sits directly in front of the FIFO; the read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of producers, ≥2.
- `DATA_WIDTH`, default 8: beat width; must match the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: bit i means requester i has a beat.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's beat is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: bit i means requester i's beat is accepted this cycle if valid.
- `fifo_full` in 1: the FIFO's `full`.
- `fifo_w_en` out 1: connects to the FIFO's `w_en`.
- `fifo_data_in` out DATA_WIDTH: connects to the FIFO's `data_in`.
- `grant_id` out $clog2(NUM_REQ): current or most recent owner.
- `busy` out 1: high while in GRANT.

## Operation
- Registered state: `state` (IDLE/GRANT), `owner`, `last_owner`, `burst_cnt` (width $clog2(MAX_BURST+1)).
- IDLE:
  - `req_ready`=0 and `fifo_w_en`=0.
  - If any `req_valid` is set, pick the first set bit scanning `last_owner+1`, `last_owner+2`, … modulo NUM_REQ.
  - Load `owner` with the winner, clear `burst_cnt`, and go to GRANT.
  - If no `req_valid` is set, stay in IDLE.
- GRANT:
  - `req_ready[owner]` = !`fifo_full`; all other `req_ready` bits are 0.
  - `fifo_w_en` = `req_valid[owner]` && !`fifo_full`; `fifo_data_in` = the owner's slice of `req_data`.
  - A transfer is `req_valid[owner]` && `req_ready[owner]`; each transfer increments `burst_cnt`.
  - Release to IDLE when either:
    - `req_valid[owner]`=0 in a cycle (no transfer that cycle), or
    - a transfer occurs with `burst_cnt`==MAX_BURST-1.
  - On release, `last_owner` ← `owner`.
- In all other cases, GRANT holds.
- `fifo_full` stall:
  - No transfer occurs and `burst_cnt` holds.
  - The grant is kept while the owner's valid stays high.
  - The owner must hold its data stable.
- Non-owner valid bits are ignored during GRANT.
- `fifo_data_in` is the owner's slice in GRANT and 0 in IDLE.
- The arbiter never asserts `fifo_w_en` while `fifo_full`=1, so no write is ever dropped.
- Reset values:
  - `state`=IDLE, `owner`=0, `last_owner`=NUM_REQ-1 (so requester 0 wins first), `burst_cnt`=0.
  - All outputs are 0.
- Reset mid-burst: the cycle after reset is sampled, the arbiter is in IDLE with all outputs 0. Beats already written stay in the FIFO; the FIFO's own reset is separate.

## Timing
- Arbitration latency is 1 cycle:
  - `req_valid` is first seen high in IDLE at cycle N.
  - GRANT is entered at cycle N+1; the first transfer can occur in cycle N+1 and is written at the rising edge ending N+1.
- In steady state, one beat per cycle while the owner is valid and the FIFO is not full.
- Every release costs exactly one IDLE cycle (bubble) before the next grant.
- `busy` and `grant_id` are registered and reflect `state`/`owner` with no combinational path from inputs.
- `req_ready` and `fifo_w_en` are combinational from the registered state plus `fifo_full` and `req_valid[owner]`.
- The arbiter adds no combinational path from `req_valid` to its own `req_ready`.

## Test plan
- Reset, then requester 0 alone holds valid with data 0x10..0x15, MAX_BURST=4:
  - 0x10–0x13 are written in cycles 1–4, then one IDLE cycle.
  - Re-grant to 0; 0x14–0x15 are written.
  - `grant_id`=0 throughout.
- Requesters 0 and 1 hold valid continuously:
  - Grants alternate 0,1,0,1, 4 beats each, with one bubble between grants.
  - The FIFO content order matches.
- All 4 requesters raise valid in the same cycle right after reset:
  - Grant order is 0,1,2,3,0.
  - No requester gets two grants before every other has had one.
- `fifo_full` forced to 1 for 3 cycles mid-burst (after beat 2):
  - `fifo_w_en`=0 and `req_ready`=0 during the stall; `burst_cnt` holds; the grant is kept.
  - Beats 3–4 follow the stall, then release.
  - No beat is lost or duplicated.
- Owner drops valid after beat 1 of 4:
  - Release to IDLE in that cycle, and `last_owner` is updated.
  - A pending requester 2 is granted two cycles later.
- `rst_n` asserted during beat 2 of a burst:
  - The next cycle shows `busy`=0, `fifo_w_en`=0, `req_ready`=0, `grant_id`=0.
  - After release of reset, requester 0 wins first.
